redis_cmd_arbiter: RTL and testbench

Round-robin command arbiter that shares one `redis_cache_top` instance among `NUM_REQ` independent requesters. It accepts one command at a time, forwards it to the cache command port, and routes the single cache response back to the requester that issued it. It sits between client front-ends (host bridge, TTL sweeper, debug port) and the cache top.

---
 rtl/redis_cache_pkg.sv | 21 ++
 rtl/redis_cmd_arbiter_if.sv | 54 +++++
 rtl/redis_cmd_arbiter_rr_arbiter.sv | 30 +++
 rtl/redis_cmd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_redis_cmd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/redis_cache_pkg.sv
// Shared constants and types for the redis cache block and its command arbiter.
package redis_cache_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_KEY_WIDTH   = 64;
    localparam int DEF_VALUE_WIDTH = 64;
    localparam int DEF_TTL_WIDTH   = 32;
    localparam int DEF_CMD_WIDTH   = 8;

    localparam logic [7:0] CMD_GET = 8'h01;
    localparam logic [7:0] CMD_SET = 8'h02;
    localparam logic [7:0] CMD_DEL = 8'h03;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_RESP = 2'd2,
        ARB_DELIVER   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/redis_cmd_arbiter_if.sv
// Requester-side and cache-side bundle of redis_cmd_arbiter.
// slave = arbiter view, master = requesters plus cache view.
interface redis_cmd_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32,
    parameter int CMD_WIDTH   = 8,
    parameter int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*CMD_WIDTH-1:0]   req_opcode;
    logic [NUM_REQ*KEY_WIDTH-1:0]   req_key;
    logic [NUM_REQ*VALUE_WIDTH-1:0] req_value;
    logic [NUM_REQ*TTL_WIDTH-1:0]   req_ttl;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic                           rsp_success;
    logic [VALUE_WIDTH-1:0]         rsp_value;
    logic [TTL_WIDTH-1:0]           rsp_ttl;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic                           cache_cmd_valid;
    logic [CMD_WIDTH-1:0]           cache_cmd_opcode;
    logic [KEY_WIDTH-1:0]           cache_cmd_key;
    logic [VALUE_WIDTH-1:0]         cache_cmd_value;
    logic [TTL_WIDTH-1:0]           cache_cmd_ttl;
    logic                           cache_cmd_ready;
    logic                           cache_resp_valid;
    logic                           cache_resp_success;
    logic [VALUE_WIDTH-1:0]         cache_resp_value;
    logic [TTL_WIDTH-1:0]           cache_resp_ttl;
    logic                           cache_resp_ready;
    logic                           busy;
    logic [ID_WIDTH-1:0]            grant_id;
    logic                           timeout_pulse;

    modport slave (
        input  req_valid, req_opcode, req_key, req_value, req_ttl, rsp_ready,
               cache_cmd_ready, cache_resp_valid, cache_resp_success,
               cache_resp_value, cache_resp_ttl,
        output req_ready, rsp_valid, rsp_success, rsp_value, rsp_ttl,
               cache_cmd_valid, cache_cmd_opcode, cache_cmd_key, cache_cmd_value,
               cache_cmd_ttl, cache_resp_ready, busy, grant_id, timeout_pulse
    );

    modport master (
        output req_valid, req_opcode, req_key, req_value, req_ttl, rsp_ready,
               cache_cmd_ready, cache_resp_valid, cache_resp_success,
               cache_resp_value, cache_resp_ttl,
        input  req_ready, rsp_valid, rsp_success, rsp_value, rsp_ttl,
               cache_cmd_valid, cache_cmd_opcode, cache_cmd_key, cache_cmd_value,
               cache_cmd_ttl, cache_resp_ready, busy, grant_id, timeout_pulse
    );
endinterface

// File: rtl/redis_cmd_arbiter_rr_arbiter.sv
// Combinational rotating-priority grant: first requester after last_grant wins.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any
);
    logic [ID_WIDTH-1:0] w_idx;
    logic                w_hit;

    // Scan upward from last_grant+1 with wrap, keeping the first hit only.
    always_comb begin
        grant     = {NUM_REQ{1'b0}};
        grant_idx = {ID_WIDTH{1'b0}};
        any       = 1'b0;
        w_idx     = {ID_WIDTH{1'b0}};
        w_hit     = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx        = ID_WIDTH'((int'(last_grant) + off) % NUM_REQ);
            w_hit        = req[w_idx] & ~any;
            grant[w_idx] = grant[w_idx] | w_hit;
            grant_idx    = w_hit ? w_idx : grant_idx;
            any          = any | w_hit;
        end
    end
endmodule

// File: rtl/redis_cmd_arbiter.sv
// Round-robin arbiter sharing one redis_cache_top among NUM_REQ requesters.
// Optional response watchdog enabled by defining REDIS_ARB_TIMEOUT_EN.
module redis_cmd_arbiter
    import redis_cache_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int KEY_WIDTH      = DEF_KEY_WIDTH,
    parameter int VALUE_WIDTH    = DEF_VALUE_WIDTH,
    parameter int TTL_WIDTH      = DEF_TTL_WIDTH,
    parameter int CMD_WIDTH      = DEF_CMD_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    redis_cmd_arbiter_if.slave bus
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] LSB_ONEHOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e             r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]    r_last_grant, r_gnt_id;
    logic [CMD_WIDTH-1:0]   r_opcode;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [TTL_WIDTH-1:0]   r_ttl;
    logic                   r_rsp_success;
    logic [VALUE_WIDTH-1:0] r_rsp_value;
    logic [TTL_WIDTH-1:0]   r_rsp_ttl;
    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_WIDTH-1:0]    w_grant_idx;
    logic                   w_any, w_accept, w_resp_take, w_timeout;
    logic                   w_wd_expire, w_stale;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
        .req        (w_stale ? {NUM_REQ{1'b0}} : bus.req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .any        (w_any)
    );

    // Next-state and handshake strobes for the one-outstanding-command FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_resp_take = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_ISSUE;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (bus.cache_cmd_ready) begin
                    w_state_nxt = ARB_WAIT_RESP;
                end else begin
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_WAIT_RESP: begin
                if (bus.cache_resp_valid) begin
                    w_state_nxt = ARB_DELIVER;
                    w_resp_take = 1'b1;
                end else if (w_wd_expire) begin
                    w_state_nxt = ARB_DELIVER;
                    w_timeout   = 1'b1;
                end else begin
                    w_state_nxt = ARB_WAIT_RESP;
                end
            end
            ARB_DELIVER: begin
                if (bus.rsp_ready[r_gnt_id]) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_state_nxt = ARB_DELIVER;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // State, rotation pointer and latched command fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
            r_gnt_id     <= {ID_WIDTH{1'b0}};
            r_opcode     <= {CMD_WIDTH{1'b0}};
            r_key        <= {KEY_WIDTH{1'b0}};
            r_value      <= {VALUE_WIDTH{1'b0}};
            r_ttl        <= {TTL_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_grant_idx;
                r_gnt_id     <= w_grant_idx;
                r_opcode     <= bus.req_opcode[int'(w_grant_idx)*CMD_WIDTH +: CMD_WIDTH];
                r_key        <= bus.req_key[int'(w_grant_idx)*KEY_WIDTH +: KEY_WIDTH];
                r_value      <= bus.req_value[int'(w_grant_idx)*VALUE_WIDTH +: VALUE_WIDTH];
                r_ttl        <= bus.req_ttl[int'(w_grant_idx)*TTL_WIDTH +: TTL_WIDTH];
            end
        end
    end

    // Latched response; a watchdog expiry delivers an all-zero failure.
    always_ff @(posedge clk) begin
        if (rst || w_timeout) begin
            r_rsp_success <= 1'b0;
            r_rsp_value   <= {VALUE_WIDTH{1'b0}};
            r_rsp_ttl     <= {TTL_WIDTH{1'b0}};
        end else if (w_resp_take) begin
            r_rsp_success <= bus.cache_resp_success;
            r_rsp_value   <= bus.cache_resp_value;
            r_rsp_ttl     <= bus.cache_resp_ttl;
        end
    end

`ifdef REDIS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_stale, r_timeout_pulse;

    assign w_wd_expire       = (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_stale           = r_stale;
    assign bus.timeout_pulse = r_timeout_pulse;

    // Watchdog counts WAIT_RESP cycles; stale marks a late response still owed by the cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt        <= {CNT_W{1'b0}};
            r_stale         <= 1'b0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout;
            r_wd_cnt        <= (r_state == ARB_WAIT_RESP) ? r_wd_cnt + CNT_W'(1) : {CNT_W{1'b0}};
            if (w_timeout) begin
                r_stale <= 1'b1;
            end else if (r_stale && bus.cache_resp_valid) begin
                r_stale <= 1'b0;
            end
        end
    end
`else
    assign w_wd_expire       = 1'b0;
    assign w_stale           = 1'b0;
    assign bus.timeout_pulse = 1'b0;
`endif

    assign bus.req_ready        = w_accept ? w_grant : {NUM_REQ{1'b0}};
    assign bus.cache_cmd_valid  = (r_state == ARB_ISSUE);
    assign bus.cache_cmd_opcode = r_opcode;
    assign bus.cache_cmd_key    = r_key;
    assign bus.cache_cmd_value  = r_value;
    assign bus.cache_cmd_ttl    = r_ttl;
    assign bus.cache_resp_ready = (r_state == ARB_WAIT_RESP) | w_stale;
    assign bus.rsp_valid        = (r_state == ARB_DELIVER) ? (LSB_ONEHOT << r_gnt_id)
                                                           : {NUM_REQ{1'b0}};
    assign bus.rsp_success      = r_rsp_success;
    assign bus.rsp_value        = r_rsp_value;
    assign bus.rsp_ttl          = r_rsp_ttl;
    assign bus.busy             = (r_state != ARB_IDLE);
    assign bus.grant_id         = r_gnt_id;
endmodule

// File: tb/tb_redis_cmd_arbiter.sv
// Directed bench for redis_cmd_arbiter; watchdog scenario runs when REDIS_ARB_TIMEOUT_EN is defined.
module tb_redis_cmd_arbiter;
    import redis_cache_pkg::*;

`ifdef REDIS_ARB_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    redis_cmd_arbiter_if #(.NUM_REQ(4), .KEY_WIDTH(64), .VALUE_WIDTH(64),
                           .TTL_WIDTH(32), .CMD_WIDTH(8)) bus ();

    redis_cmd_arbiter #(.NUM_REQ(4), .KEY_WIDTH(64), .VALUE_WIDTH(64), .TTL_WIDTH(32),
                        .CMD_WIDTH(8), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] op, input logic [63:0] key,
                           input logic [63:0] val, input logic [31:0] ttl);
        bus.req_opcode[i*8 +: 8]  = op;
        bus.req_key[i*64 +: 64]   = key;
        bus.req_value[i*64 +: 64] = val;
        bus.req_ttl[i*32 +: 32]   = ttl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.req_valid = 4'b0000;
        bus.req_opcode = 32'h0;
        bus.req_key = 256'h0;
        bus.req_value = 256'h0;
        bus.req_ttl = 128'h0;
        bus.rsp_ready = 4'b0000;
        bus.cache_cmd_ready = 1'b0;
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_success = 1'b0;
        bus.cache_resp_value = 64'h0;
        bus.cache_resp_ttl = 32'h0;
        do_reset();

        // Reset state
        settle();
        chk_eq("rst_busy", 64'(bus.busy), 64'h0);
        chk_eq("rst_grant_id", 64'(bus.grant_id), 64'h0);
        chk_eq("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk_eq("rst_cmd_valid", 64'(bus.cache_cmd_valid), 64'h0);
        chk_eq("rst_cmd_key", bus.cache_cmd_key, 64'h0);
        chk_eq("rst_resp_ready", 64'(bus.cache_resp_ready), 64'h0);
        chk_eq("rst_rsp_value", bus.rsp_value, 64'h0);
        chk_eq("rst_timeout", 64'(bus.timeout_pulse), 64'h0);

        // Single requester 2, zero-wait cache
        tick();
        set_req(2, CMD_SET, 64'h11, 64'hAA, 32'h5);
        bus.req_valid = 4'b0100;
        bus.cache_cmd_ready = 1'b1;
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_success = 1'b1;
        bus.cache_resp_value = 64'h77;
        bus.cache_resp_ttl = 32'h9;
        bus.rsp_ready = 4'b1111;
        settle();
        chk_eq("t1_req_ready", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        chk_eq("t1_cmd_valid", 64'(bus.cache_cmd_valid), 64'h1);
        chk_eq("t1_cmd_key", bus.cache_cmd_key, 64'h11);
        chk_eq("t1_cmd_opcode", 64'(bus.cache_cmd_opcode), 64'(CMD_SET));
        chk_eq("t1_cmd_value", bus.cache_cmd_value, 64'hAA);
        chk_eq("t1_grant_id", 64'(bus.grant_id), 64'h2);
        tick();
        settle();
        chk_eq("t1_resp_ready", 64'(bus.cache_resp_ready), 64'h1);
        tick();
        settle();
        chk_eq("t1_rsp_valid", 64'(bus.rsp_valid), 64'h4);
        chk_eq("t1_rsp_success", 64'(bus.rsp_success), 64'h1);
        chk_eq("t1_rsp_value", bus.rsp_value, 64'h77);
        tick();
        settle();
        chk_eq("t1_idle_busy", 64'(bus.busy), 64'h0);

        // All four valid continuously: strict rotation from requester 0
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, CMD_GET, 64'h100 + 64'(i), 64'h0, 32'h0);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            logic [3:0] exp_oh;
            exp_oh = 4'b0001 << (n % 4);
            bus.cache_resp_value = 64'h5000 + 64'(n);
            settle();
            chk_eq("t2_req_ready", 64'(bus.req_ready), 64'(exp_oh));
            tick();
            settle();
            chk_eq("t2_grant_id", 64'(bus.grant_id), 64'(n % 4));
            chk_eq("t2_cmd_key", bus.cache_cmd_key, 64'h100 + 64'(n % 4));
            tick();
            tick();
            settle();
            chk_eq("t2_rsp_valid", 64'(bus.rsp_valid), 64'(exp_oh));
            chk_eq("t2_rsp_value", bus.rsp_value, 64'h5000 + 64'(n));
            tick();
        end

        // Backpressure on both cache command and requester response, GET from requester 1
        do_reset();
        set_req(1, CMD_GET, 64'h22, 64'h0, 32'h0);
        bus.req_valid = 4'b0010;
        bus.cache_cmd_ready = 1'b0;
        bus.cache_resp_valid = 1'b0;
        bus.rsp_ready = 4'b0000;
        settle();
        chk_eq("t3_req_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 4'b1101;
        repeat (5) begin
            settle();
            chk_eq("t3_cmd_valid", 64'(bus.cache_cmd_valid), 64'h1);
            chk_eq("t3_cmd_key", bus.cache_cmd_key, 64'h22);
            chk_eq("t3_cmd_opcode", 64'(bus.cache_cmd_opcode), 64'(CMD_GET));
            chk_eq("t3_busy", 64'(bus.busy), 64'h1);
            chk_eq("t3_no_req_ready", 64'(bus.req_ready), 64'h0);
            tick();
        end
        bus.cache_cmd_ready = 1'b1;
        settle();
        chk_eq("t3_cmd_valid_last", 64'(bus.cache_cmd_valid), 64'h1);
        tick();
        bus.cache_cmd_ready = 1'b0;
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_success = 1'b1;
        bus.cache_resp_value = 64'h33;
        bus.cache_resp_ttl = 32'h44;
        settle();
        chk_eq("t3_resp_ready", 64'(bus.cache_resp_ready), 64'h1);
        tick();
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_value = 64'hDEAD;
        bus.rsp_ready = 4'b1101;
        repeat (3) begin
            settle();
            chk_eq("t3_rsp_valid", 64'(bus.rsp_valid), 64'h2);
            chk_eq("t3_rsp_value", bus.rsp_value, 64'h33);
            chk_eq("t3_rsp_ttl", 64'(bus.rsp_ttl), 64'h44);
            chk_eq("t3_busy_dlv", 64'(bus.busy), 64'h1);
            chk_eq("t3_no_req_ready_dlv", 64'(bus.req_ready), 64'h0);
            tick();
        end
        bus.rsp_ready = 4'b0010;
        bus.req_valid = 4'b0000;
        settle();
        chk_eq("t3_rsp_valid_end", 64'(bus.rsp_valid), 64'h2);
        tick();
        settle();
        chk_eq("t3_idle", 64'(bus.busy), 64'h0);

        // Skip idle requesters: last_grant is 1, only 0 and 3 valid
        set_req(0, CMD_DEL, 64'h30, 64'h0, 32'h0);
        set_req(3, CMD_GET, 64'h33, 64'h0, 32'h0);
        bus.req_valid = 4'b1001;
        bus.cache_cmd_ready = 1'b1;
        bus.cache_resp_valid = 1'b1;
        bus.rsp_ready = 4'b1111;
        settle();
        chk_eq("t4_req_ready_3", 64'(bus.req_ready), 64'h8);
        tick();
        settle();
        chk_eq("t4_grant_3", 64'(bus.grant_id), 64'h3);
        chk_eq("t4_key_3", bus.cache_cmd_key, 64'h33);
        tick();
        tick();
        tick();
        settle();
        chk_eq("t4_req_ready_0", 64'(bus.req_ready), 64'h1);
        tick();
        settle();
        chk_eq("t4_grant_0", 64'(bus.grant_id), 64'h0);
        chk_eq("t4_key_0", bus.cache_cmd_key, 64'h30);
        bus.req_valid = 4'b0000;
        tick();
        tick();
        tick();

        // Reset during WAIT_RESP
        bus.req_valid = 4'b0100;
        bus.cache_resp_valid = 1'b0;
        settle();
        chk_eq("t5_req_ready", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        settle();
        chk_eq("t5_wait_resp_ready", 64'(bus.cache_resp_ready), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk_eq("t5_busy", 64'(bus.busy), 64'h0);
        chk_eq("t5_grant_id", 64'(bus.grant_id), 64'h0);
        chk_eq("t5_resp_ready", 64'(bus.cache_resp_ready), 64'h0);
        chk_eq("t5_cmd_valid", 64'(bus.cache_cmd_valid), 64'h0);
        chk_eq("t5_cmd_key", bus.cache_cmd_key, 64'h0);
        chk_eq("t5_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        bus.req_valid = 4'b1111;
        settle();
        chk_eq("t5_first_grant", 64'(bus.req_ready), 64'h1);
        tick();
        settle();
        chk_eq("t5_grant_id_0", 64'(bus.grant_id), 64'h0);
        bus.req_valid = 4'b0000;
        bus.cache_resp_valid = 1'b1;
        tick();
        tick();
        tick();

`ifdef REDIS_ARB_TIMEOUT_EN
        // Watchdog expiry, then a late response that must be absorbed
        do_reset();
        bus.cache_cmd_ready = 1'b1;
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_success = 1'b1;
        bus.cache_resp_value = 64'h99;
        bus.rsp_ready = 4'b1111;
        bus.req_valid = 4'b0001;
        settle();
        chk_eq("t6_req_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int k = 0; k < 16; k++) begin
            settle();
            chk_eq("t6_wait_rsp_valid", 64'(bus.rsp_valid), 64'h0);
            chk_eq("t6_wait_pulse", 64'(bus.timeout_pulse), 64'h0);
            tick();
        end
        settle();
        chk_eq("t6_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk_eq("t6_rsp_success", 64'(bus.rsp_success), 64'h0);
        chk_eq("t6_rsp_value", bus.rsp_value, 64'h0);
        chk_eq("t6_pulse", 64'(bus.timeout_pulse), 64'h1);
        tick();
        bus.req_valid = 4'b0010;
        settle();
        chk_eq("t6_pulse_gone", 64'(bus.timeout_pulse), 64'h0);
        repeat (3) begin
            settle();
            chk_eq("t6_stale_no_grant", 64'(bus.req_ready), 64'h0);
            chk_eq("t6_stale_resp_ready", 64'(bus.cache_resp_ready), 64'h1);
            tick();
        end
        bus.cache_resp_valid = 1'b1;
        settle();
        chk_eq("t6_absorb_no_grant", 64'(bus.req_ready), 64'h0);
        tick();
        bus.cache_resp_valid = 1'b0;
        settle();
        chk_eq("t6_grant_after", 64'(bus.req_ready), 64'h2);
        chk_eq("t6_busy_idle", 64'(bus.busy), 64'h0);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        chk_eq("t6_grant_id", 64'(bus.grant_id), 64'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
